// File: rtl/alu_cmd_sequencer.sv
// Initiator-side sequencer for an 8-bit combinational ALU: queues commands,
// drives registered operands, captures results and returns them with a sequence tag.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [3:0]       cmd_sel,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_carry,
  output logic             res_err,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 8 + 8 + 4 + TAG_W;
  localparam logic [3:0]  SEL_DIV = 4'b0011;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           r_state;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [TAG_W-1:0] r_tag;
  logic [TAG_W-1:0] r_ptag;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic [3:0]       r_alu_sel;
  logic             r_res_valid;
  logic [7:0]       r_res_data;
  logic             r_res_carry;
  logic             r_res_err;
  logic [TAG_W-1:0] r_res_tag;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_div0;
  logic [EW-1:0]    w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = cmd_valid && !w_full;
  // The head is consumed whenever the FSM launches the next command.
  assign w_pop   = !w_empty && ((r_state == S_IDLE) || ((r_state == S_RESP) && res_ready));
  assign w_head  = r_mem[r_rptr];
  assign w_div0  = (r_alu_sel == SEL_DIV) && (r_alu_b == 8'h00);

  assign cmd_ready = !w_full;
  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_carry = r_res_carry;
  assign res_err   = r_res_err;
  assign res_tag   = r_res_tag;

  // Storage is not reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {cmd_a, cmd_b, cmd_sel, r_tag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_tag   <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
        r_tag  <= r_tag + TAG_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptag      <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_carry <= 1'b0;
      r_res_err   <= 1'b0;
      r_res_tag   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_alu_a, r_alu_b, r_alu_sel, r_ptag} <= w_head;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res_data  <= w_div0 ? 8'hFF : alu_out;
          r_res_err   <= w_div0;
          r_res_carry <= alu_carry;
          r_res_tag   <= r_ptag;
          r_res_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (w_pop) begin
              {r_alu_a, r_alu_b, r_alu_sel, r_ptag} <= w_head;
              r_state <= S_EXEC;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 8-bit ALU attached.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic [3:0] cmd_sel = '0;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_carry, res_err;
  logic [3:0] res_tag;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_sequencer #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_err(res_err),
    .res_tag(res_tag), .busy(busy)
  );

  // Reference ALU: {carry, result}; carry is always that of A+B.
  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    logic [8:0] sum;
    logic [7:0] r;
    sum = 9'(a) + 9'(b);
    case (s)
      4'h0: r = sum[7:0];
      4'h1: r = a - b;
      4'h2: r = 8'(a * b);
      4'h3: r = (b == 8'h00) ? 8'h00 : a / b;
      4'h4: r = a << 1;
      4'h5: r = a >> 1;
      4'h6: r = {a[6:0], a[7]};
      4'h7: r = {a[0], a[7:1]};
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = ~(a | b);
      4'hC: r = ~(a & b);
      4'hD: r = ~(a ^ b);
      4'hE: r = (a > b) ? 8'd1 : 8'd0;
      default: r = (a == b) ? 8'd1 : 8'd0;
    endcase
    return {sum[8], r};
  endfunction

  assign {alu_carry, alu_out} = alu_model(alu_a, alu_b, alu_sel);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s, output bit ok);
    ok = 1'b0;
    cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (cmd_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic get_res(output logic [7:0] d, output logic c, output logic e, output logic [3:0] t,
                         output int unsigned at, output bit ok);
    ok = 1'b0; d = '0; c = 1'b0; e = 1'b0; t = '0; at = 0;
    for (int i = 0; i < 80; i++) begin
      if (res_valid && res_ready) begin
        d = res_data; c = res_carry; e = res_err; t = res_tag; at = cyc; ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({alu_a, alu_b, alu_sel, res_valid, res_data, res_carry, res_err, res_tag, busy} !== '0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values: got alu=%h/%h/%h res=%b/%h/%b/%b/%h busy=%b rdy=%b, want all 0 and rdy=1",
               alu_a, alu_b, alu_sel, res_valid, res_data, res_carry, res_err, res_tag, busy, cmd_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    res_ready = 1'b1;
    cmd_a = 8'd200; cmd_b = 8'd100; cmd_sel = 4'b0000; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat1: res_valid=%b want 0", res_valid); end
    tick();
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_lat2: res_valid=%b busy=%b want 0/1", res_valid, busy);
    end
    tick();
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 8'd44 || res_carry !== 1'b1 || res_err !== 1'b0 || res_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL basic_result: v=%b d=%0d c=%b e=%b t=%0d want 1/44/1/0/0", res_valid, res_data, res_carry, res_err, res_tag);
    end
    tick();
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle: res_valid=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_div();
    logic [7:0] d; logic c, e; logic [3:0] t; int unsigned at; bit ok;
    do_reset();
    res_ready = 1'b1;
    push_cmd(8'd9, 8'd0, 4'b0011, ok);
    get_res(d, c, e, t, at, ok);
    n_checks++;
    if (!ok || d !== 8'hFF || e !== 1'b1 || c !== 1'b0 || t !== 4'd0) begin
      n_fail++; $display("FAIL div_zero: ok=%b d=%h e=%b c=%b t=%0d want FF/1/0/0", ok, d, e, c, t);
    end
    push_cmd(8'd9, 8'd3, 4'b0011, ok);
    get_res(d, c, e, t, at, ok);
    n_checks++;
    if (!ok || d !== 8'd3 || e !== 1'b0 || c !== 1'b0 || t !== 4'd1) begin
      n_fail++; $display("FAIL div_normal: ok=%b d=%0d e=%b c=%b t=%0d want 3/0/0/1", ok, d, e, c, t);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [13:0] snap;
    bit stable;
    do_reset();
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      if (acc < 7) begin
        cmd_valid = 1'b1; cmd_a = 8'(acc * 10 + 5); cmd_b = 8'(acc + 1); cmd_sel = 4'b0000;
      end else begin
        cmd_valid = 1'b0;
      end
      if (cmd_valid && cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (acc != 5 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_capacity: accepted=%0d cmd_ready=%b want 5/0", acc, cmd_ready);
    end
    snap = {res_valid, res_data, res_carry, res_err, res_tag[2:0]};
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if ({res_valid, res_data, res_carry, res_err, res_tag[2:0]} !== snap) stable = 1'b0;
    end
    n_checks++;
    if (!stable || res_valid !== 1'b1 || res_tag !== 4'd0 || res_data !== 8'd6) begin
      n_fail++; $display("FAIL bp_hold: stable=%b v=%b t=%0d d=%0d want 1/1/0/6", stable, res_valid, res_tag, res_data);
    end
    res_ready = 1'b1;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_first_pop: cmd_ready=%b res_valid=%b want 1/0", cmd_ready, res_valid);
    end
    for (int i = 1; i < 5; i++) begin
      tick();
      n_checks++;
      if (res_valid !== 1'b1 || res_tag !== 4'(i) || res_data !== 8'(11 * i + 6)) begin
        n_fail++; $display("FAIL bp_drain%0d: v=%b t=%0d d=%0d want 1/%0d/%0d", i, res_valid, res_tag, res_data, i, 11 * i + 6);
      end
      tick();
      n_checks++;
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_gap%0d: res_valid=%b want 0", i, res_valid); end
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy: busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    res_ready = 1'b1;
    fork
      begin
        bit ok;
        for (int i = 0; i < 18; i++) begin
          push_cmd(8'(i * 7), 8'(i * 7), 4'b1111, ok);
          n_checks++;
          if (!ok) begin n_fail++; $display("FAIL b2b_push%0d: timed out, want accept", i); end
        end
      end
      begin
        logic [7:0] d; logic c, e; logic [3:0] t; int unsigned at, prev; bit ok;
        prev = 0;
        for (int i = 0; i < 18; i++) begin
          get_res(d, c, e, t, at, ok);
          n_checks++;
          if (!ok || d !== 8'd1 || e !== 1'b0 || t !== 4'(i % 16)) begin
            n_fail++; $display("FAIL b2b_res%0d: ok=%b d=%0d e=%b t=%0d want 1/0/%0d", i, ok, d, e, t, i % 16);
          end
          if (i > 0) begin
            n_checks++;
            if (at - prev != 2) begin n_fail++; $display("FAIL b2b_rate%0d: gap=%0d want 2", i, at - prev); end
          end
          prev = at;
        end
      end
    join
  endtask

  task automatic test_async_reset();
    logic [7:0] d; logic c, e; logic [3:0] t; int unsigned at; bit ok; bit clean;
    do_reset();
    cmd_valid = 1'b1; cmd_a = 8'd10; cmd_b = 8'd20; cmd_sel = 4'b0000;
    tick();
    cmd_a = 8'd11; cmd_b = 8'd21;
    tick();
    cmd_a = 8'd12; cmd_b = 8'd22;
    tick();
    cmd_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({alu_a, alu_b, alu_sel, res_valid, res_data, res_carry, res_err, res_tag, busy} !== '0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: alu=%h/%h/%h v=%b d=%h busy=%b rdy=%b want 0s and rdy=1",
               alu_a, alu_b, alu_sel, res_valid, res_data, busy, cmd_ready);
    end
    #2 rst = 1'b0;
    res_ready = 1'b1;
    clean = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (res_valid !== 1'b0 || busy !== 1'b0) clean = 1'b0;
    end
    n_checks++;
    if (!clean) begin n_fail++; $display("FAIL async_stale: result or busy appeared after reset, want none"); end
    push_cmd(8'd1, 8'd2, 4'b0000, ok);
    get_res(d, c, e, t, at, ok);
    n_checks++;
    if (!ok || d !== 8'd3 || t !== 4'd0 || c !== 1'b0) begin
      n_fail++; $display("FAIL async_post: ok=%b d=%0d t=%0d c=%b want 3/0/0", ok, d, t, c);
    end
  endtask

  task automatic test_mix();
    logic [7:0] va [20];
    logic [7:0] vb [20];
    logic [3:0] vs [20];
    for (int i = 0; i < 20; i++) begin
      vs[i] = 4'(i % 16);
      va[i] = 8'(37 * i + 11);
      vb[i] = (i == 3) ? 8'd0 : 8'(13 * i + 5);
    end
    do_reset();
    fork
      begin
        bit ok;
        for (int i = 0; i < 20; i++) begin
          push_cmd(va[i], vb[i], vs[i], ok);
          n_checks++;
          if (!ok) begin n_fail++; $display("FAIL mix_push%0d: timed out, want accept", i); end
        end
      end
      begin
        int got;
        logic [8:0] m;
        logic [7:0] ed;
        logic ee;
        got = 0;
        for (int c = 0; c < 600 && got < 20; c++) begin
          res_ready = ((c * 5 + c / 3) % 3) != 0;
          if (res_valid && res_ready) begin
            m  = alu_model(va[got], vb[got], vs[got]);
            ee = (vs[got] == 4'b0011) && (vb[got] == 8'd0);
            ed = ee ? 8'hFF : m[7:0];
            n_checks++;
            if (res_data !== ed || res_carry !== m[8] || res_err !== ee || res_tag !== 4'(got % 16)) begin
              n_fail++;
              $display("FAIL mix_res%0d: d=%h c=%b e=%b t=%0d want %h/%b/%b/%0d",
                       got, res_data, res_carry, res_err, res_tag, ed, m[8], ee, got % 16);
            end
            got++;
          end
          tick();
        end
        n_checks++;
        if (got != 20) begin n_fail++; $display("FAIL mix_count: got %0d results want 20", got); end
        res_ready = 1'b0;
      end
    join
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_mix();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
